// File: rtl/mpu_exec_seq.sv
// rtl/mpu_exec_seq.sv - sequential MPU execution stage
//   sys_clk, sys_rst_n          : clock, synchronous active-low reset
//   op_valid/op_ready, op_*     : decoded instruction handshake and fields, isize
//   alu_res, lo_*               : external ALU result on the latched operands / opcode / size
//   ip_stb/ip_incr/ip_load/ip_data : retire pulse, instruction size, jump taken and target
//   we/w_idx/w_data/w_r_sel/w_size : register file write port
//   hm_start/hm_addr/hm_ack/hm_data: host memory read request and response
//   user_irq/user_data/user_ack : user interrupt level, payload and acknowledge
//   hm_err/err_clr              : sticky host-read timeout flag and its clear
module mpu_exec_seq #(
  parameter int DW         = 64,
  parameter int IPW        = 16,
  parameter int HM_TIMEOUT = 255
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [IPW-1:0] isize,
  input  logic [3:0]     op_op,
  input  logic [1:0]     op_size,
  input  logic [DW-1:0]  op_o0,
  input  logic [DW-1:0]  op_o1,
  input  logic [DW-1:0]  op_o2,
  input  logic [DW-1:0]  op_o3,
  input  logic [4:0]     op_idx0,
  input  logic [2:0]     op_s0,
  input  logic [DW-1:0]  alu_res,
  output logic [DW-1:0]  lo_o0,
  output logic [DW-1:0]  lo_o1,
  output logic [DW-1:0]  lo_o2,
  output logic [3:0]     lo_op,
  output logic [1:0]     lo_size,
  output logic           ip_stb,
  output logic [IPW-1:0] ip_incr,
  output logic           ip_load,
  output logic [IPW-1:0] ip_data,
  output logic           we,
  output logic [4:0]     w_idx,
  output logic [DW-1:0]  w_data,
  output logic [2:0]     w_r_sel,
  output logic [1:0]     w_size,
  output logic           hm_start,
  output logic [DW-1:0]  hm_addr,
  input  logic           hm_ack,
  input  logic [DW-1:0]  hm_data,
  output logic           user_irq,
  output logic [DW-1:0]  user_data,
  input  logic           user_ack,
  output logic           hm_err,
  input  logic           err_clr
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_HAMM  = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_JMP   = 4'd3;
  localparam logic [3:0] OP_MASK  = 4'd4;
  localparam logic [3:0] OP_CMP   = 4'd5;
  localparam logic [3:0] OP_LT    = 4'd6;
  localparam logic [3:0] OP_MLOAD = 4'd7;
  localparam logic [3:0] OP_INT   = 4'd8;

  // Counter holds elapsed HM_WAIT cycles minus one; it never reaches HM_TIMEOUT.
  localparam int CW = $clog2(HM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HM_WAIT, S_IRQ_WAIT} state_t;

  state_t         state_q, state_d;
  logic           op_ready_q, op_ready_d;
  logic [DW-1:0]  lo_o0_q, lo_o0_d, lo_o1_q, lo_o1_d, lo_o2_q, lo_o2_d, lo_o3_q, lo_o3_d;
  logic [3:0]     lo_op_q, lo_op_d;
  logic [1:0]     lo_size_q, lo_size_d;
  logic [4:0]     lo_idx_q, lo_idx_d;
  logic [2:0]     lo_sel_q, lo_sel_d;
  logic [IPW-1:0] lo_isize_q, lo_isize_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ip_stb_q, ip_stb_d, ip_load_q, ip_load_d;
  logic [IPW-1:0] ip_incr_q, ip_incr_d, ip_data_q, ip_data_d;
  logic           we_q, we_d;
  logic [4:0]     w_idx_q, w_idx_d;
  logic [DW-1:0]  w_data_q, w_data_d;
  logic [2:0]     w_r_sel_q, w_r_sel_d;
  logic [1:0]     w_size_q, w_size_d;
  logic           hm_start_q, hm_start_d;
  logic [DW-1:0]  hm_addr_q, hm_addr_d;
  logic           user_irq_q, user_irq_d;
  logic [DW-1:0]  user_data_q, user_data_d;
  logic           hm_err_q, hm_err_d;

  // Per-cycle decisions, folded into the registered outputs after the state case.
  logic           retire, wr, jmp, hm_set;
  logic [DW-1:0]  wr_data;
  logic [IPW-1:0] jmp_tgt;
  logic [CW:0]    cnt_inc;

  always_comb begin
    state_d     = state_q;
    lo_o0_d     = lo_o0_q;
    lo_o1_d     = lo_o1_q;
    lo_o2_d     = lo_o2_q;
    lo_o3_d     = lo_o3_q;
    lo_op_d     = lo_op_q;
    lo_size_d   = lo_size_q;
    lo_idx_d    = lo_idx_q;
    lo_sel_d    = lo_sel_q;
    lo_isize_d  = lo_isize_q;
    cnt_d       = cnt_q;
    hm_start_d  = 1'b0;
    hm_addr_d   = hm_addr_q;
    user_irq_d  = user_irq_q;
    user_data_d = user_data_q;
    retire      = 1'b0;
    wr          = 1'b0;
    wr_data     = '0;
    jmp         = 1'b0;
    jmp_tgt     = '0;
    hm_set      = 1'b0;
    cnt_inc     = {1'b0, cnt_q} + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready_q) begin
          lo_o0_d    = op_o0;
          lo_o1_d    = op_o1;
          lo_o2_d    = op_o2;
          lo_o3_d    = op_o3;
          lo_op_d    = op_op;
          lo_size_d  = op_size;
          lo_idx_d   = op_idx0;
          lo_sel_d   = op_s0;
          lo_isize_d = isize;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (lo_op_q)
          OP_ADD, OP_HAMM: begin
            retire  = 1'b1;
            wr      = 1'b1;
            wr_data = alu_res;
          end
          OP_LOAD: begin
            retire  = 1'b1;
            wr      = 1'b1;
            wr_data = lo_o1_q;
          end
          OP_JMP: begin
            retire  = 1'b1;
            jmp     = 1'b1;
            jmp_tgt = lo_o0_q[IPW-1:0];
          end
          OP_MASK, OP_CMP: begin
            // ALU bit 0 set means the condition held, i.e. fall through.
            retire  = 1'b1;
            jmp     = ~alu_res[0];
            jmp_tgt = lo_o3_q[IPW-1:0];
          end
          OP_LT: begin
            retire  = 1'b1;
            jmp     = ~alu_res[0];
            jmp_tgt = lo_o2_q[IPW-1:0];
          end
          OP_MLOAD: begin
            hm_start_d = 1'b1;
            hm_addr_d  = lo_o1_q;
            cnt_d      = '0;
            state_d    = S_HM_WAIT;
          end
          OP_INT: begin
            user_irq_d  = 1'b1;
            user_data_d = lo_o0_q;
            state_d     = S_IRQ_WAIT;
          end
          default: retire = 1'b1;
        endcase
      end
      S_HM_WAIT: begin
        // Ack is checked first so an ack on the final wait cycle still writes.
        if (hm_ack) begin
          retire    = 1'b1;
          wr        = 1'b1;
          wr_data   = hm_data;
          hm_addr_d = '0;
          state_d   = S_IDLE;
        end else if (cnt_inc == (CW+1)'(HM_TIMEOUT)) begin
          retire    = 1'b1;
          hm_set    = 1'b1;
          hm_addr_d = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
      S_IRQ_WAIT: begin
        if (user_ack) begin
          retire      = 1'b1;
          user_irq_d  = 1'b0;
          user_data_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    op_ready_d = (state_d == S_IDLE);
    ip_stb_d   = retire;
    ip_incr_d  = retire ? lo_isize_q : '0;
    ip_load_d  = retire & jmp;
    ip_data_d  = (retire && jmp) ? jmp_tgt : '0;
    we_d       = wr;
    w_data_d   = wr ? wr_data : '0;
    w_idx_d    = wr ? lo_idx_q : '0;
    w_r_sel_d  = wr ? lo_sel_q : '0;
    w_size_d   = wr ? lo_size_q : '0;
    // Timeout set takes priority over a same-cycle clear.
    hm_err_d   = hm_set ? 1'b1 : (err_clr ? 1'b0 : hm_err_q);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      op_ready_q  <= 1'b0;
      lo_o0_q     <= '0;
      lo_o1_q     <= '0;
      lo_o2_q     <= '0;
      lo_o3_q     <= '0;
      lo_op_q     <= '0;
      lo_size_q   <= '0;
      lo_idx_q    <= '0;
      lo_sel_q    <= '0;
      lo_isize_q  <= '0;
      cnt_q       <= '0;
      ip_stb_q    <= 1'b0;
      ip_incr_q   <= '0;
      ip_load_q   <= 1'b0;
      ip_data_q   <= '0;
      we_q        <= 1'b0;
      w_idx_q     <= '0;
      w_data_q    <= '0;
      w_r_sel_q   <= '0;
      w_size_q    <= '0;
      hm_start_q  <= 1'b0;
      hm_addr_q   <= '0;
      user_irq_q  <= 1'b0;
      user_data_q <= '0;
      hm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_ready_q  <= op_ready_d;
      lo_o0_q     <= lo_o0_d;
      lo_o1_q     <= lo_o1_d;
      lo_o2_q     <= lo_o2_d;
      lo_o3_q     <= lo_o3_d;
      lo_op_q     <= lo_op_d;
      lo_size_q   <= lo_size_d;
      lo_idx_q    <= lo_idx_d;
      lo_sel_q    <= lo_sel_d;
      lo_isize_q  <= lo_isize_d;
      cnt_q       <= cnt_d;
      ip_stb_q    <= ip_stb_d;
      ip_incr_q   <= ip_incr_d;
      ip_load_q   <= ip_load_d;
      ip_data_q   <= ip_data_d;
      we_q        <= we_d;
      w_idx_q     <= w_idx_d;
      w_data_q    <= w_data_d;
      w_r_sel_q   <= w_r_sel_d;
      w_size_q    <= w_size_d;
      hm_start_q  <= hm_start_d;
      hm_addr_q   <= hm_addr_d;
      user_irq_q  <= user_irq_d;
      user_data_q <= user_data_d;
      hm_err_q    <= hm_err_d;
    end
  end

  assign op_ready  = op_ready_q;
  assign lo_o0     = lo_o0_q;
  assign lo_o1     = lo_o1_q;
  assign lo_o2     = lo_o2_q;
  assign lo_op     = lo_op_q;
  assign lo_size   = lo_size_q;
  assign ip_stb    = ip_stb_q;
  assign ip_incr   = ip_incr_q;
  assign ip_load   = ip_load_q;
  assign ip_data   = ip_data_q;
  assign we        = we_q;
  assign w_idx     = w_idx_q;
  assign w_data    = w_data_q;
  assign w_r_sel   = w_r_sel_q;
  assign w_size    = w_size_q;
  assign hm_start  = hm_start_q;
  assign hm_addr   = hm_addr_q;
  assign user_irq  = user_irq_q;
  assign user_data = user_data_q;
  assign hm_err    = hm_err_q;

endmodule

// File: tb/tb_mpu_exec_seq.sv
// tb/tb_mpu_exec_seq.sv - scoreboard bench for mpu_exec_seq (long and short host-read timeout)
module tb_mpu_exec_seq;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_HAMM  = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_JMP   = 4'd3;
  localparam logic [3:0] OP_MASK  = 4'd4;
  localparam logic [3:0] OP_CMP   = 4'd5;
  localparam logic [3:0] OP_LT    = 4'd6;
  localparam logic [3:0] OP_MLOAD = 4'd7;
  localparam logic [3:0] OP_INT   = 4'd8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, op_valid, hm_ack, user_ack, err_clr;
  logic [15:0] isize;
  logic [3:0]  op_op;
  logic [1:0]  op_size;
  logic [63:0] o0, o1, o2, o3, alu_res, hm_data;
  logic [4:0]  idx;
  logic [2:0]  s0;

  logic        op_ready, ip_stb, ip_load, we, hm_start, user_irq, hm_err;
  logic [63:0] lo_o0, lo_o1, lo_o2, w_data, hm_addr, user_data;
  logic [3:0]  lo_op;
  logic [1:0]  lo_size, w_size;
  logic [15:0] ip_incr, ip_data;
  logic [4:0]  w_idx;
  logic [2:0]  w_r_sel;

  logic        t_op_ready, t_ip_stb, t_ip_load, t_we, t_hm_start, t_user_irq, t_hm_err;
  logic [63:0] t_lo_o0, t_lo_o1, t_lo_o2, t_w_data, t_hm_addr, t_user_data;
  logic [3:0]  t_lo_op;
  logic [1:0]  t_lo_size, t_w_size;
  logic [15:0] t_ip_incr, t_ip_data;
  logic [4:0]  t_w_idx;
  logic [2:0]  t_w_r_sel;

  mpu_exec_seq #(.DW(64), .IPW(16), .HM_TIMEOUT(255)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .isize(isize), .op_op(op_op), .op_size(op_size),
    .op_o0(o0), .op_o1(o1), .op_o2(o2), .op_o3(o3), .op_idx0(idx), .op_s0(s0),
    .alu_res(alu_res), .lo_o0(lo_o0), .lo_o1(lo_o1), .lo_o2(lo_o2), .lo_op(lo_op), .lo_size(lo_size),
    .ip_stb(ip_stb), .ip_incr(ip_incr), .ip_load(ip_load), .ip_data(ip_data),
    .we(we), .w_idx(w_idx), .w_data(w_data), .w_r_sel(w_r_sel), .w_size(w_size),
    .hm_start(hm_start), .hm_addr(hm_addr), .hm_ack(hm_ack), .hm_data(hm_data),
    .user_irq(user_irq), .user_data(user_data), .user_ack(user_ack),
    .hm_err(hm_err), .err_clr(err_clr)
  );

  mpu_exec_seq #(.DW(64), .IPW(16), .HM_TIMEOUT(4)) dut_t (
    .sys_clk(clk), .sys_rst_n(rst_n), .op_valid(op_valid), .op_ready(t_op_ready),
    .isize(isize), .op_op(op_op), .op_size(op_size),
    .op_o0(o0), .op_o1(o1), .op_o2(o2), .op_o3(o3), .op_idx0(idx), .op_s0(s0),
    .alu_res(alu_res), .lo_o0(t_lo_o0), .lo_o1(t_lo_o1), .lo_o2(t_lo_o2), .lo_op(t_lo_op), .lo_size(t_lo_size),
    .ip_stb(t_ip_stb), .ip_incr(t_ip_incr), .ip_load(t_ip_load), .ip_data(t_ip_data),
    .we(t_we), .w_idx(t_w_idx), .w_data(t_w_data), .w_r_sel(t_w_r_sel), .w_size(t_w_size),
    .hm_start(t_hm_start), .hm_addr(t_hm_addr), .hm_ack(hm_ack), .hm_data(hm_data),
    .user_irq(t_user_irq), .user_data(t_user_data), .user_ack(user_ack),
    .hm_err(t_hm_err), .err_clr(err_clr)
  );

  typedef struct {
    logic        we;
    logic [63:0] w_data;
    logic [4:0]  w_idx;
    logic [2:0]  w_sel;
    logic [1:0]  w_size;
    logic [15:0] incr;
    logic        load;
    logic [15:0] ipd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic w, input logic [63:0] d, input logic [4:0] ix, input logic [2:0] sel,
                      input logic [1:0] sz, input logic [15:0] inc, input logic ld, input logic [15:0] ipd);
    exp_t e;
    e.we = w; e.w_data = d; e.w_idx = ix; e.w_sel = sel; e.w_size = sz;
    e.incr = inc; e.load = ld; e.ipd = ipd;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a0, input logic [63:0] a1,
                       input logic [63:0] a2, input logic [63:0] a3, input logic [63:0] alu,
                       input logic [4:0] ix, input logic [2:0] sel, input logic [1:0] sz,
                       input logic [15:0] isz);
    int n;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", 64'(op_ready), 64'd1);
    op_op = op; o0 = a0; o1 = a1; o2 = a2; o3 = a3; alu_res = alu;
    idx = ix; s0 = sel; op_size = sz; isize = isz;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  // Scoreboard monitor: every retire on the main instance must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (we && !ip_stb) begin
        n_checks++;
        n_fail++;
        $display("FAIL we_without_retire: we=%0b ip_stb=%0b", we, ip_stb);
      end
      if (ip_stb) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: ip_stb=1 we=%0b w_data=%h with no expected retire", we, w_data);
        end else begin
          e = sb.pop_front();
          chk("sb_we", 64'(we), 64'(e.we));
          if (e.we) begin
            chk("sb_w_data", w_data, e.w_data);
            chk("sb_w_idx", 64'(w_idx), 64'(e.w_idx));
            chk("sb_w_r_sel", 64'(w_r_sel), 64'(e.w_sel));
            chk("sb_w_size", 64'(w_size), 64'(e.w_size));
          end
          chk("sb_ip_incr", 64'(ip_incr), 64'(e.incr));
          chk("sb_ip_load", 64'(ip_load), 64'(e.load));
          chk("sb_ip_data", 64'(ip_data), 64'(e.ipd));
          chk("sb_hm_err", 64'(hm_err), 64'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic found;
    rst_n = 1'b0; op_valid = 1'b0; hm_ack = 1'b0; user_ack = 1'b0; err_clr = 1'b0;
    isize = '0; op_op = '0; op_size = '0; o0 = '0; o1 = '0; o2 = '0; o3 = '0;
    idx = '0; s0 = '0; alu_res = '0; hm_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_outputs_main", 64'(|{ip_stb, ip_load, we, hm_start, user_irq, hm_err, lo_o0, lo_o1, lo_o2,
        lo_op, lo_size, ip_incr, ip_data, w_idx, w_data, w_r_sel, w_size, hm_addr, user_data}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_op_ready", 64'(op_ready), 64'd1);

    // Simple ops
    push(1'b1, 64'h5, 5'd7, 3'd3, 2'd2, 16'd4, 1'b0, 16'h0);
    issue(OP_ADD, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 5'd7, 3'd3, 2'd2, 16'd4);
    @(negedge clk);
    chk("exec_op_ready_low", 64'(op_ready), 64'd0);
    chk("exec_no_retire_yet", 64'(ip_stb), 64'd0);

    push(1'b1, 64'h3, 5'd1, 3'd1, 2'd3, 16'd2, 1'b0, 16'h0);
    issue(OP_HAMM, 64'hF, 64'h0, 64'h0, 64'h0, 64'h3, 5'd1, 3'd1, 2'd3, 16'd2);
    push(1'b1, 64'hABCD_0000_1234_5678, 5'd31, 3'd7, 2'd1, 16'd6, 1'b0, 16'h0);
    issue(OP_LOAD, 64'h0, 64'hABCD_0000_1234_5678, 64'h0, 64'h0, 64'h999, 5'd31, 3'd7, 2'd1, 16'd6);
    push(1'b0, 64'h0, 5'd0, 3'd0, 2'd0, 16'd3, 1'b1, 16'h0040);
    issue(OP_CMP, 64'h0, 64'h0, 64'h0, 64'h0040, 64'h0, 5'd2, 3'd0, 2'd0, 16'd3);
    push(1'b0, 64'h0, 5'd0, 3'd0, 2'd0, 16'd3, 1'b0, 16'h0);
    issue(OP_CMP, 64'h0, 64'h0, 64'h0, 64'h0040, 64'h1, 5'd2, 3'd0, 2'd0, 16'd3);
    push(1'b0, 64'h0, 5'd0, 3'd0, 2'd0, 16'd8, 1'b1, 16'h0123);
    issue(OP_MASK, 64'h0, 64'h0, 64'h0, 64'hFFFF_0123, 64'h2, 5'd0, 3'd0, 2'd0, 16'd8);
    push(1'b0, 64'h0, 5'd0, 3'd0, 2'd0, 16'd5, 1'b1, 16'h2345);
    issue(OP_JMP, 64'h1_2345, 64'h0, 64'h0, 64'h0, 64'h1, 5'd0, 3'd0, 2'd0, 16'd5);
    push(1'b0, 64'h0, 5'd0, 3'd0, 2'd0, 16'd1, 1'b1, 16'h0055);
    issue(OP_LT, 64'h0, 64'h0, 64'h55, 64'h66, 64'h0, 5'd0, 3'd0, 2'd0, 16'd1);
    push(1'b0, 64'h0, 5'd0, 3'd0, 2'd0, 16'd1, 1'b0, 16'h0);
    issue(OP_LT, 64'h0, 64'h0, 64'h55, 64'h66, 64'h1, 5'd0, 3'd0, 2'd0, 16'd1);
    push(1'b0, 64'h0, 5'd0, 3'd0, 2'd0, 16'd9, 1'b0, 16'h0);
    issue(4'd15, 64'h7, 64'h7, 64'h7, 64'h7, 64'h0, 5'd3, 3'd2, 2'd1, 16'd9);

    // MLOAD with ack 5 cycles after hm_start
    push(1'b1, 64'hDEAD, 5'd9, 3'd4, 2'd3, 16'd4, 1'b0, 16'h0);
    issue(OP_MLOAD, 64'h0, 64'h1000, 64'h0, 64'h0, 64'h0, 5'd9, 3'd4, 2'd3, 16'd4);
    @(negedge clk);
    chk("mload_exec_no_start", 64'(hm_start), 64'd0);
    cyc();
    @(negedge clk);
    chk("mload_hm_start", 64'(hm_start), 64'd1);
    chk("mload_hm_addr", hm_addr, 64'h1000);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("mload_start_one_cycle", 64'(hm_start), 64'd0);
      chk("mload_addr_held", hm_addr, 64'h1000);
      chk("mload_not_ready", 64'(op_ready), 64'd0);
    end
    cyc();
    hm_ack = 1'b1; hm_data = 64'hDEAD;
    cyc();
    hm_ack = 1'b0;

    // Short-timeout instance: abort after 4 wait cycles
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    @(negedge clk);
    chk("t_err_cleared", 64'(t_hm_err), 64'd0);
    push(1'b1, 64'hBEEF, 5'd4, 3'd1, 2'd0, 16'd2, 1'b0, 16'h0);
    issue(OP_MLOAD, 64'h0, 64'h2000, 64'h0, 64'h0, 64'h0, 5'd4, 3'd1, 2'd0, 16'd2);
    n = 0; found = 1'b0;
    while (n < 20 && !found) begin
      @(negedge clk);
      n++;
      if (t_ip_stb) found = 1'b1;
    end
    chk("t_timeout_latency", 64'(n), 64'd6);
    chk("t_timeout_no_we", 64'(t_we), 64'd0);
    chk("t_timeout_err", 64'(t_hm_err), 64'd1);
    chk("main_still_waiting", 64'(op_ready), 64'd0);
    cyc();
    @(negedge clk);
    chk("t_err_sticky", 64'(t_hm_err), 64'd1);
    chk("t_stb_one_cycle", 64'(t_ip_stb), 64'd0);
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    @(negedge clk);
    chk("t_err_clr", 64'(t_hm_err), 64'd0);
    cyc();
    hm_ack = 1'b1; hm_data = 64'hBEEF;
    cyc();
    hm_ack = 1'b0;
    @(negedge clk);
    chk("t_ack_ignored_idle", 64'(t_ip_stb), 64'd0);

    // Timeout set wins over a simultaneous clear
    push(1'b1, 64'h5A5A, 5'd6, 3'd2, 2'd1, 16'd3, 1'b0, 16'h0);
    err_clr = 1'b1;
    issue(OP_MLOAD, 64'h0, 64'h2500, 64'h0, 64'h0, 64'h0, 5'd6, 3'd2, 2'd1, 16'd3);
    n = 0; found = 1'b0;
    while (n < 20 && !found) begin
      @(negedge clk);
      n++;
      if (t_ip_stb) found = 1'b1;
    end
    chk("t_set_wins_latency", 64'(n), 64'd6);
    chk("t_set_wins", 64'(t_hm_err), 64'd1);
    cyc();
    @(negedge clk);
    chk("t_clr_after_set", 64'(t_hm_err), 64'd0);
    err_clr = 1'b0;
    cyc();
    hm_ack = 1'b1; hm_data = 64'h5A5A;
    cyc();
    hm_ack = 1'b0;

    // Ack on the timeout cycle: ack wins
    push(1'b1, 64'hCAFE, 5'd5, 3'd6, 2'd2, 16'd7, 1'b0, 16'h0);
    issue(OP_MLOAD, 64'h0, 64'h3000, 64'h0, 64'h0, 64'h0, 5'd5, 3'd6, 2'd2, 16'd7);
    repeat (3) cyc();
    cyc();
    hm_ack = 1'b1; hm_data = 64'hCAFE;
    cyc();
    hm_ack = 1'b0;
    @(negedge clk);
    chk("t_ack_wins_stb", 64'(t_ip_stb), 64'd1);
    chk("t_ack_wins_we", 64'(t_we), 64'd1);
    chk("t_ack_wins_data", t_w_data, 64'hCAFE);
    chk("t_ack_wins_no_err", 64'(t_hm_err), 64'd0);

    // Early user_ack in IDLE is ignored, then INT held for 10 cycles
    cyc();
    user_ack = 1'b1;
    cyc();
    user_ack = 1'b0;
    @(negedge clk);
    chk("early_ack_no_irq", 64'(user_irq), 64'd0);
    chk("early_ack_no_stb", 64'(ip_stb), 64'd0);
    push(1'b0, 64'h0, 5'd0, 3'd0, 2'd0, 16'd5, 1'b0, 16'h0);
    issue(OP_INT, 64'h77, 64'h0, 64'h0, 64'h0, 64'h0, 5'd0, 3'd0, 2'd0, 16'd5);
    @(negedge clk);
    chk("int_exec_irq_low", 64'(user_irq), 64'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i == 10) user_ack = 1'b1;
      @(negedge clk);
      chk("int_irq_held", 64'(user_irq), 64'd1);
      chk("int_user_data", user_data, 64'h77);
    end
    cyc();
    user_ack = 1'b0;
    @(negedge clk);
    chk("int_irq_cleared", 64'(user_irq), 64'd0);

    // Reset during HM_WAIT
    issue(OP_MLOAD, 64'h0, 64'h4000, 64'h0, 64'h0, 64'h0, 5'd8, 3'd1, 2'd1, 16'd4);
    repeat (2) cyc();
    @(negedge clk);
    chk("hm_wait_addr", hm_addr, 64'h4000);
    cyc();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_hm_main", 64'(|{op_ready, ip_stb, ip_load, we, hm_start, user_irq, hm_err, lo_o0, lo_o1, lo_o2,
        lo_op, lo_size, ip_incr, ip_data, w_idx, w_data, w_r_sel, w_size, hm_addr, user_data}), 64'd0);
    chk("rst_hm_short", 64'(|{t_op_ready, t_ip_stb, t_ip_load, t_we, t_hm_start, t_user_irq, t_hm_err,
        t_lo_o0, t_lo_o1, t_lo_o2, t_lo_op, t_lo_size, t_ip_incr, t_ip_data, t_w_idx, t_w_data,
        t_w_r_sel, t_w_size, t_hm_addr, t_user_data}), 64'd0);
    rst_n = 1'b1;
    cyc();
    hm_ack = 1'b1; hm_data = 64'h1111;
    cyc();
    hm_ack = 1'b0;
    @(negedge clk);
    chk("rst_late_ack_no_we", 64'(we), 64'd0);
    chk("rst_late_ack_no_stb", 64'(ip_stb), 64'd0);

    // Reset during IRQ_WAIT
    issue(OP_INT, 64'h99, 64'h0, 64'h0, 64'h0, 64'h0, 5'd0, 3'd0, 2'd0, 16'd2);
    repeat (3) cyc();
    @(negedge clk);
    chk("irq_wait_level", 64'(user_irq), 64'd1);
    cyc();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_irq_level", 64'(user_irq), 64'd0);
    chk("rst_irq_data", user_data, 64'd0);
    chk("rst_irq_ready", 64'(op_ready), 64'd0);
    rst_n = 1'b1;
    cyc();
    user_ack = 1'b1;
    cyc();
    user_ack = 1'b0;
    @(negedge clk);
    chk("rst_late_uack_no_stb", 64'(ip_stb), 64'd0);

    repeat (5) cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
